// File: rtl/ari_tx_arbiter_if.sv
// Channel-side Avalon-ST and ARI-side signals of the TX arbiter.
// slave is the arbiter's view; master is the driving environment.
interface ari_tx_arbiter_if;
    logic [31:0] i_ch0_data;
    logic        i_ch0_valid;
    logic        i_ch0_sop;
    logic        i_ch0_eop;
    logic [1:0]  i_ch0_empty;
    logic        o_ch0_ready;

    logic [31:0] i_ch1_data;
    logic        i_ch1_valid;
    logic        i_ch1_sop;
    logic        i_ch1_eop;
    logic [1:0]  i_ch1_empty;
    logic        o_ch1_ready;

    logic        o_ari_val;
    logic        o_ari_sof;
    logic        o_ari_eof;
    logic [31:0] o_ari_data;
    logic [1:0]  o_ari_be;
    logic        i_ari_ack;
    logic [14:0] o_ari_frame_len;
    logic        o_ari_frame_len_val;

    modport slave (
        input  i_ch0_data, i_ch0_valid, i_ch0_sop, i_ch0_eop, i_ch0_empty,
        output o_ch0_ready,
        input  i_ch1_data, i_ch1_valid, i_ch1_sop, i_ch1_eop, i_ch1_empty,
        output o_ch1_ready,
        output o_ari_val, o_ari_sof, o_ari_eof, o_ari_data, o_ari_be,
        input  i_ari_ack,
        output o_ari_frame_len, o_ari_frame_len_val
    );

    modport master (
        output i_ch0_data, i_ch0_valid, i_ch0_sop, i_ch0_eop, i_ch0_empty,
        input  o_ch0_ready,
        output i_ch1_data, i_ch1_valid, i_ch1_sop, i_ch1_eop, i_ch1_empty,
        input  o_ch1_ready,
        input  o_ari_val, o_ari_sof, o_ari_eof, o_ari_data, o_ari_be,
        output i_ari_ack,
        input  o_ari_frame_len, o_ari_frame_len_val
    );
endinterface

// File: rtl/ari_tx_arbiter.sv
// Two-channel Avalon-ST to ARI packet arbiter: strips the length word,
// round-robin on simultaneous start, zero-latency payload pass-through.
module ari_tx_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    ari_tx_arbiter_if.slave  bus,
    output logic [1:0]       o_grant,
    output logic [CNT_W-1:0] o_pkt_cnt0,
    output logic [CNT_W-1:0] o_pkt_cnt1,
    output logic             o_err
);

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        SOF,
        DATA
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_q, last_d;
    logic [14:0]      flen_q, flen_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;
    logic             inc0, inc1;

    logic             g_valid;
    logic             g_eop;
    logic [31:0]      g_data;
    logic [1:0]       g_empty;

    logic             req0, req1;
    logic             flush0, flush1;
    logic [1:0]       rdy;
    logic             val, sof, eof, fval;

    // Granted-channel mux; an all-ones empty makes byte enables zero when idle
    always_comb begin
        g_valid = 1'b0;
        g_eop   = 1'b0;
        g_data  = '0;
        g_empty = 2'b11;
        unique case (1'b1)
            grant_q[0]: begin
                g_valid = bus.i_ch0_valid;
                g_eop   = bus.i_ch0_eop;
                g_data  = bus.i_ch0_data;
                g_empty = bus.i_ch0_empty;
            end
            grant_q[1]: begin
                g_valid = bus.i_ch1_valid;
                g_eop   = bus.i_ch1_eop;
                g_data  = bus.i_ch1_data;
                g_empty = bus.i_ch1_empty;
            end
            default: ;
        endcase
    end

    assign req0   = bus.i_ch0_valid & bus.i_ch0_sop;
    assign req1   = bus.i_ch1_valid & bus.i_ch1_sop;
    assign flush0 = bus.i_ch0_valid & ~bus.i_ch0_sop;
    assign flush1 = bus.i_ch1_valid & ~bus.i_ch1_sop;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        flen_d  = flen_q;
        err_d   = 1'b0;
        rdy     = 2'b00;
        val     = 1'b0;
        sof     = 1'b0;
        eof     = 1'b0;
        fval    = 1'b0;
        inc0    = 1'b0;
        inc1    = 1'b0;
        unique case (state_q)
            IDLE: begin
                rdy   = {flush1, flush0};
                err_d = flush0 | flush1;
                if (req0 && req1) begin
                    grant_d = last_q ? 2'b01 : 2'b10;
                end else if (req0) begin
                    grant_d = 2'b01;
                end else if (req1) begin
                    grant_d = 2'b10;
                end
                if (req0 || req1) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                rdy = grant_q;
                if (g_valid) begin
                    flen_d = g_data[14:0];
                    if (g_eop) begin
                        // A packet with no payload is dropped
                        err_d   = 1'b1;
                        last_d  = grant_q[1];
                        grant_d = 2'b00;
                        state_d = IDLE;
                    end else begin
                        state_d = SOF;
                    end
                end
            end
            SOF, DATA: begin
                val  = g_valid;
                sof  = g_valid & (state_q == SOF);
                eof  = g_eop;
                fval = 1'b1;
                rdy  = grant_q & {2{bus.i_ari_ack}};
                if (g_valid && bus.i_ari_ack) begin
                    if (g_eop) begin
                        last_d  = grant_q[1];
                        grant_d = 2'b00;
                        inc0    = grant_q[0];
                        inc1    = grant_q[1];
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            flen_q  <= '0;
            err_q   <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            flen_q  <= flen_d;
            err_q   <= err_d;
            if (inc0) begin
                cnt0_q <= cnt0_q + 1'b1;
            end
            if (inc1) begin
                cnt1_q <= cnt1_q + 1'b1;
            end
        end
    end

    // Flush readies are input-driven, so hold them off during reset
    assign bus.o_ch0_ready         = rdy[0] & i_rst_n;
    assign bus.o_ch1_ready         = rdy[1] & i_rst_n;
    assign bus.o_ari_val           = val;
    assign bus.o_ari_sof           = sof;
    assign bus.o_ari_eof           = eof;
    assign bus.o_ari_data          = g_data;
    assign bus.o_ari_be            = ~g_empty;
    assign bus.o_ari_frame_len     = flen_q;
    assign bus.o_ari_frame_len_val = fval;

    assign o_grant    = grant_q;
    assign o_pkt_cnt0 = cnt0_q;
    assign o_pkt_cnt1 = cnt1_q;
    assign o_err      = err_q;

endmodule

// File: doc/ari_tx_arbiter.md
ARI_TX_ARBITER -- requirements
Module: ari_tx_arbiter

Interface
- REQ-001: Parameter CNT_W, default 16: width of per-channel packet counters.
- REQ-002: i_clk  in  1  clock; all logic on rising edge.
- REQ-003: i_rst_n  in  1  reset, asynchronous, active-low.
- REQ-004: i_chN_data  in  32  channel N (N=0,1) Avalon-ST data; first word of a packet carries frame length in [14:0].
- REQ-005: i_chN_valid / i_chN_sop / i_chN_eop  in  1 each  channel N valid, startofpacket, endofpacket.
- REQ-006: i_chN_empty  in  2  channel N empty bytes, meaningful on eop word.
- REQ-007: o_chN_ready  out  1  channel N ready; transfer = valid & ready.
- REQ-008: o_ari_val / o_ari_sof / o_ari_eof  out  1 each  ARI word valid, first payload word, last payload word.
- REQ-009: o_ari_data  out  32  ARI payload word.
- REQ-010: o_ari_be  out  2  ARI byte enable, ~empty of granted channel.
- REQ-011: i_ari_ack  in  1  ARI accepts current word when o_ari_val=1.
- REQ-012: o_ari_frame_len  out  15  frame length of current packet; o_ari_frame_len_val  out  1  length valid.
- REQ-013: o_grant  out  2  one-hot granted channel, 2'b00 when none.
- REQ-014: o_pkt_cntN  out  CNT_W  completed packets per channel; o_err  out  1  one-cycle error pulse.

Function
- REQ-015: FSM states IDLE, LEN, SOF, DATA; registered state, one-hot grant register, last-grant pointer.
- REQ-016: IDLE: requester = valid & sop; one requester -> grant it; both -> grant channel other than last-granted; next state LEN.
- REQ-017: IDLE: any channel with valid & ~sop gets ready=1 (word flushed), o_err pulses next cycle; flush has priority over arbitration for that channel only.
- REQ-018: LEN: granted ready=1; on transfer capture data[14:0] into o_ari_frame_len, go SOF; wait in LEN while valid=0.
- REQ-019: LEN transfer with eop=1: packet dropped, o_err pulse, return IDLE, pointer updated, counter not incremented.
- REQ-020: SOF: o_ari_val = granted valid, o_ari_sof = granted valid, granted ready = i_ari_ack; on valid & ack -> DATA, or IDLE if eop.
- REQ-021: DATA: o_ari_val = granted valid, o_ari_sof=0; on valid & ack & eop -> IDLE.
- REQ-022: o_ari_eof = granted eop while in SOF/DATA, else 0; o_ari_data, o_ari_be mux granted channel combinationally.
- REQ-023: o_ari_frame_len_val = 1 exactly while state is SOF or DATA; o_ari_frame_len holds until next LEN capture.
- REQ-024: Non-granted channel ready=0 in LEN/SOF/DATA; grant is packet-atomic, never changes mid-packet.
- REQ-025: i_ari_ack while o_ari_val=0 is ignored.
- REQ-026: On eop accept: last-grant pointer = granted channel, o_pkt_cntN increments by 1, wraps modulo 2^CNT_W.
- REQ-027: Zero latency from channel to ARI: data word visible on ARI in same cycle it is presented.
- REQ-028: Back-to-back packets: IDLE entered for one cycle minimum between packets.

Reset
- REQ-029: Asynchronous reset forces state IDLE, grant 2'b00, pointer = ch1 (ch0 wins first tie), frame_len 0, counters 0, o_err 0.
- REQ-030: During reset all ready, o_ari_val/sof/eof, o_ari_frame_len_val = 0; reset mid-packet abandons packet, no counter change.

Verification
- REQ-031: ch0 sends len=0x0008 + 2 words, ack always 1 -> frame_len=8, val high 2 cycles, sof on word1, eof on word2, o_pkt_cnt0=1.
- REQ-032: ch0 and ch1 sop same cycle after reset -> ch0 granted; next simultaneous request -> ch1 granted.
- REQ-033: ack held 0 for 5 cycles in DATA -> o_ari_val/data stable, o_chN_ready=0, no advance; ch1 requesting meanwhile stays ungranted.
- REQ-034: ch1 valid without sop in IDLE -> word flushed, o_err pulse, o_grant stays 00.
- REQ-035: length word with eop -> o_err pulse, no ARI val, counter unchanged; reset asserted mid-DATA -> all outputs reset values, next packet starts cleanly.
